// File: rtl/seg_pkg.sv
// Shared definitions for the snake game display scheduler: phase encoding,
// decimal-point patterns and BCD digit limits.
package seg_pkg;

  // Game phase; the encoding is also what state_o reports.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Point after the minutes digits separates MM from SS; the extra point on
  // the rightmost digit marks a paused game.
  localparam logic [5:0] POINT_NORMAL = 6'b000100;
  localparam logic [5:0] POINT_PAUSE  = 6'b000101;

  // Largest value of a decimal digit and of the tens-of-seconds digit.
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

  // Out-of-range BCD digits from the game core are shown as 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_mmss_timer.sv
// Elapsed-time stopwatch: a sys_clk prescaler producing a 1 s tick and a
// saturating BCD MM:SS counter (stops at 99:59). clr wins over en.
module bcd_mmss_timer
  import seg_pkg::*;
#(
  parameter int SEC_CNT_MAX = 49_999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic       tick,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd
);

  localparam int PW = (SEC_CNT_MAX > 0) ? $clog2(SEC_CNT_MAX + 1) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(SEC_CNT_MAX);

  logic [PW-1:0] presc;
  logic [3:0]    sec_ones;
  logic [3:0]    sec_tens;
  logic [3:0]    min_ones;
  logic [3:0]    min_tens;
  logic          at_max;

  assign tick    = en && (presc == PRESC_TOP);
  assign at_max  = (min_tens == BCD_DIGIT_MAX) && (min_ones == BCD_DIGIT_MAX) &&
                   (sec_tens == BCD_TENS_MAX) && (sec_ones == BCD_DIGIT_MAX);
  assign min_bcd = {min_tens, min_ones};
  assign sec_bcd = {sec_tens, sec_ones};

  // Prescaler wraps every second; each wrap advances MM:SS with BCD carries
  // unless the counter already shows 99:59.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else if (clr) begin
      presc    <= '0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else if (en) begin
      if (tick) begin
        presc <= '0;
        if (!at_max) begin
          if (sec_ones != BCD_DIGIT_MAX) begin
            sec_ones <= sec_ones + 4'd1;
          end else begin
            sec_ones <= 4'd0;
            if (sec_tens != BCD_TENS_MAX) begin
              sec_tens <= sec_tens + 4'd1;
            end else begin
              sec_tens <= 4'd0;
              if (min_ones != BCD_DIGIT_MAX) begin
                min_ones <= min_ones + 4'd1;
              end else begin
                min_ones <= 4'd0;
                min_tens <= min_tens + 4'd1;
              end
            end
          end
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_disp_ctrl.sv
// Display scheduler for the snake game's 6-digit 595 display: game phase
// FSM, score latch, game-over blink and the registered BCD output word.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int SEC_CNT_MAX   = 49_999_999,
  parameter int BLINK_CNT_MAX = 12_499_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start_signal,
  input  logic        clear_signal,
  input  logic        pause_signal,
  input  logic        game_over,
  input  logic [7:0]  score_bcd,
  output logic [23:0] disp_bcd,
  output logic [5:0]  point,
  output logic        seg_en,
  output logic        sign,
  output logic [1:0]  state_o
);

  localparam int BW = (BLINK_CNT_MAX > 0) ? $clog2(BLINK_CNT_MAX + 1) : 1;
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_CNT_MAX);

  state_t        state;
  logic          ev_clear;
  logic          ev_over;
  logic          ev_pause;
  logic          ev_start;
  logic          timer_en;
  logic          timer_clr;
  logic          sec_tick;
  logic [7:0]    min_bcd;
  logic [7:0]    sec_bcd;
  logic [3:0]    score_tens;
  logic [3:0]    score_ones;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // Coinciding pulses resolve to a single event: clear > game_over > pause
  // > start. A higher pulse that the current phase ignores still masks the
  // lower ones.
  assign ev_clear = clear_signal;
  assign ev_over  = game_over & ~clear_signal;
  assign ev_pause = pause_signal & ~clear_signal & ~game_over;
  assign ev_start = start_signal & ~clear_signal & ~game_over & ~pause_signal;

  // Time runs only in RUN, judged on the current phase so a tick on the
  // cycle that leaves RUN still lands. Clearing zeroes the timer in the same
  // edge that returns to IDLE, and IDLE keeps it at zero.
  assign timer_en  = (state == ST_RUN);
  assign timer_clr = ev_clear || (state == ST_IDLE);

  bcd_mmss_timer #(
    .SEC_CNT_MAX(SEC_CNT_MAX)
  ) u_timer (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .en     (timer_en),
    .clr    (timer_clr),
    .tick   (sec_tick),
    .min_bcd(min_bcd),
    .sec_bcd(sec_bcd)
  );

  // Phase transitions plus the output register, which presents the
  // pre-edge phase, counters and latch one cycle later.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      disp_bcd <= 24'h000000;
      point    <= 6'b000000;
      seg_en   <= 1'b0;
      sign     <= 1'b0;
      state_o  <= 2'd0;
    end else begin
      disp_bcd <= {score_tens, score_ones, min_bcd, sec_bcd};
      point    <= (state == ST_PAUSE) ? POINT_PAUSE : POINT_NORMAL;
      seg_en   <= (state == ST_OVER) ? blink_on : 1'b1;
      sign     <= 1'b0;
      state_o  <= state;
      if (ev_clear) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:  if (ev_start) state <= ST_RUN;
          ST_RUN: begin
            if (ev_over)       state <= ST_OVER;
            else if (ev_pause) state <= ST_PAUSE;
          end
          ST_PAUSE: begin
            if (ev_over)                     state <= ST_OVER;
            else if (ev_pause || ev_start)   state <= ST_RUN;
          end
          ST_OVER:  state <= ST_OVER;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  // Score follows the game core while running, freezes in PAUSE and OVER
  // (OVER keeps the value loaded on the game_over cycle), zero in IDLE.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      score_tens <= 4'd0;
      score_ones <= 4'd0;
    end else if (ev_clear || (state == ST_IDLE)) begin
      score_tens <= 4'd0;
      score_ones <= 4'd0;
    end else if (state == ST_RUN) begin
      score_tens <= clamp_bcd(score_bcd[7:4]);
      score_ones <= clamp_bcd(score_bcd[3:0]);
    end
  end

  // Blink runs only in OVER; held idle elsewhere so OVER always starts with
  // the display lit and a fresh half-period.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (state != ST_OVER) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_TOP) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // A second can only elapse while the game is running.
  always @(posedge sys_clk) begin
    if (!sys_rst && sec_tick) begin
      assert (state == ST_RUN);
    end
  end

endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
- Display scheduler for the snake game's 6-digit 7-seg/74HC595 path.
- Sequences game phases (idle/run/pause/over) and runs an MM:SS elapsed-time stopwatch.
- Multiplexes score and timer into one 6-digit BCD word with point/enable/sign for the dynamic 595 driver.
- Sits between the game core (start/clear/pause/game-over pulses, BCD score) and the 595 scan driver.

Parameters:
- SEC_CNT_MAX, 49_999_999: prescaler terminal count; one 1 s tick every SEC_CNT_MAX+1 sys_clk cycles.
- BLINK_CNT_MAX, 12_499_999: blink half-period terminal count in sys_clk cycles.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- start_signal  in  1  1-cycle pulse: start or resume.
- clear_signal  in  1  1-cycle pulse: return to idle, zero timer.
- pause_signal  in  1  1-cycle pulse: toggle pause.
- game_over  in  1  1-cycle pulse from game core.
- score_bcd  in  8  two BCD digits {tens, ones}.
- disp_bcd  out  24  six BCD digits, [23:20] = leftmost digit.
- point  out  6  decimal points, bit i = digit i (bit 0 = rightmost).
- seg_en  out  1  display enable.
- sign  out  1  minus sign; constant 0.
- state_o  out  2  current state: 0=IDLE, 1=RUN, 2=PAUSE, 3=OVER.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; timer 00:00; prescaler 0; blink counter 0; score latch 00; disp_bcd 0; point 0; seg_en 0; sign 0; state_o 0.
- All outputs are registered and reflect state/counters with 1-cycle latency. The first cycle after reset release drives IDLE outputs.
- Display layout:
  - disp_bcd = {score_tens, score_ones, min_tens, min_ones, sec_tens, sec_ones}.
  - point = 6'b000100 (separator after minutes) in IDLE, RUN and OVER.
  - point = 6'b000101 in PAUSE (digit-0 point marks pause).
- Event priority when pulses coincide: clear > game_over > pause > start. Only the highest-priority event acts in a given cycle.
- IDLE:
  - timer 00:00, prescaler 0, score latch 00, seg_en=1.
  - start -> RUN.
  - pause and game_over are ignored.
- RUN:
  - score latch loads score_bcd every cycle.
  - prescaler increments each cycle; at SEC_CNT_MAX it wraps to 0 and the timer increments.
  - pause -> PAUSE; game_over -> OVER; clear -> IDLE.
- PAUSE:
  - prescaler, timer and score latch frozen; seg_en=1.
  - pause or start -> RUN, prescaler resumes from its held value.
  - game_over -> OVER; clear -> IDLE.
- OVER:
  - score latch and timer frozen at their values on the entry cycle.
  - blink counter runs; seg_en toggles at each BLINK_CNT_MAX wrap, starting at 1 on entry.
  - clear -> IDLE; all other events ignored.
- Blink counter is held at 0 outside OVER, and is cleared to 0 on entry to OVER.
- Timer arithmetic (BCD):
  - sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into minutes.
  - min_ones 9->0 carries into min_tens.
  - At 99:59 the timer saturates: no wrap, holds 99:59.
- A score digit > 9 on input is clamped to 9 when latched.
- A tick coinciding with a state change out of RUN is still applied: timer increments, then the new state takes effect.
- Reset mid-operation returns immediately to reset values, regardless of state.

Decomposition:
- Shared package seg_pkg:
  - state encoding constants ST_IDLE/ST_RUN/ST_PAUSE/ST_OVER.
  - POINT_NORMAL = 6'b000100, POINT_PAUSE = 6'b000101.
  - BCD digit max constants (9, 5).
- One sub-module: bcd_mmss_timer. Holds the prescaler plus the saturating BCD MM:SS counter, with en/clr inputs and a tick output. The FSM, score latch, blink and output mux stay in seg_disp_ctrl.

Test Plan (SEC_CNT_MAX=9, BLINK_CNT_MAX=3):
- Reset and release -> all outputs 0 during reset. Next cycle: state_o=0, seg_en=1, point=6'b000100, disp_bcd=24'h000000.
- start, score_bcd=8'h42, run 600 cycles -> disp_bcd=24'h420100 (01:00) with state_o=1. Then score_bcd=8'h4A -> score digits read 49.
- In RUN at 00:07: pause, wait 50 cycles, pause again -> timer holds 00:07 and point=6'b000101 while paused. Time resumes with no lost partial second.
- Force the timer to 99:58, run 30 cycles -> shows 99:59 and stays. Then pause, start and clear on the same cycle -> state_o=0, timer 00:00.
- game_over at score 8'h17 -> state_o=3, score frozen at 17 despite score_bcd changes. seg_en toggles every 4 cycles starting at 1. start is ignored; clear -> IDLE.
- Assert sys_rst mid-RUN, asynchronous to sys_clk -> outputs 0 immediately. After release, IDLE behaviour per scenario 1.
